clk_div_prog: RTL and testbench

- Runtime-programmable integer clock divider for the FIR sample/clock generation path.
- Generalises the fixed-ratio toggle divider: parametrised counter width, divide ratio loaded through a valid/ready handshake, and run/hold enable.
- Ratio updates take effect only at period boundaries, so clk_out never has a runt pulse.
- Besides clk_out, provides single-cycle rise/fall strobes in the clk_in domain. FIR stages use these as clock enables instead of clocking on clk_out.

---
 rtl/clk_div_prog.sv | 117 +++++++++++
 tb/tb_clk_div_prog.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with clk_in-domain rise/fall strobes.
// Define CLK_DIV_DUTY_EN to make the high time programmable through div_high.
module clk_div_prog #(
    parameter int          CNT_W       = 16,
    parameter int unsigned DIV_DEFAULT = 126
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             en,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic [CNT_W-1:0] div_value,
    input  logic [CNT_W-1:0] div_high,
    output logic             clk_out,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             cfg_err,
    output logic [CNT_W-1:0] cur_div
);

    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] H_INIT   = DIV_INIT >> 1;
    localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(2);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cur_div_reg;
    logic [CNT_W-1:0] h_act_reg;
    logic [CNT_W-1:0] pend_div_reg;
    logic             clk_out_reg;
    logic             rise_reg;
    logic             fall_reg;
    logic             cfg_err_reg;
    logic             ready_reg;

    logic             wrap;
    logic             high_now;
    logic             handshake;
    logic             accept;
    logic [CNT_W-1:0] apply_h;

    assign wrap      = (cnt_reg == cur_div_reg - 1'b1);
    assign high_now  = (cnt_reg < h_act_reg);
    assign handshake = div_valid && ready_reg;
    assign accept    = handshake && (div_value >= MIN_DIV);

`ifdef CLK_DIV_DUTY_EN
    logic [CNT_W-1:0] pend_h_reg;
    logic [CNT_W-1:0] req_h;

    // Out-of-range high times fall back to the balanced (low-biased) duty cycle
    assign req_h   = (div_high == '0 || div_high >= div_value) ? (div_value >> 1) : div_high;
    assign apply_h = pend_h_reg;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            pend_h_reg <= H_INIT;
        end else if (accept) begin
            pend_h_reg <= req_h;
        end
    end
`else
    logic unused_div_high;

    assign unused_div_high = ^div_high;
    assign apply_h         = pend_div_reg >> 1;
`endif

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg      <= '0;
            cur_div_reg  <= DIV_INIT;
            h_act_reg    <= H_INIT;
            pend_div_reg <= DIV_INIT;
            clk_out_reg  <= 1'b0;
            rise_reg     <= 1'b0;
            fall_reg     <= 1'b0;
            cfg_err_reg  <= 1'b0;
            ready_reg    <= 1'b1;
        end else begin
            rise_reg    <= 1'b0;
            fall_reg    <= 1'b0;
            cfg_err_reg <= 1'b0;
            if (en) begin
                clk_out_reg <= high_now;
                rise_reg    <= high_now && !clk_out_reg;
                fall_reg    <= !high_now && clk_out_reg;
                if (wrap) begin
                    cnt_reg <= '0;
                    // ready low means a ratio is pending; it takes over at the restart
                    if (!ready_reg) begin
                        cur_div_reg <= pend_div_reg;
                        h_act_reg   <= apply_h;
                        ready_reg   <= 1'b1;
                    end
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            if (handshake) begin
                if (accept) begin
                    pend_div_reg <= div_value;
                    ready_reg    <= 1'b0;
                end else begin
                    cfg_err_reg <= 1'b1;
                end
            end
        end
    end

    assign div_ready = ready_reg;
    assign clk_out   = clk_out_reg;
    assign rise_tick = rise_reg;
    assign fall_tick = fall_reg;
    assign cfg_err   = cfg_err_reg;
    assign cur_div   = cur_div_reg;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: an event-level period model predicts every
// rise/fall strobe; a monitor pops and compares them as the DUT produces them.
module tb_clk_div_prog;

    localparam int CNT_W   = 16;
    localparam int DIV_DEF = 126;

    logic             clk_in = 1'b0;
    logic             reset_n = 1'b1;
    logic             en = 1'b0;
    logic             div_valid = 1'b0;
    logic [CNT_W-1:0] div_value = '0;
    logic [CNT_W-1:0] div_high = '0;
    logic             div_ready;
    logic             clk_out;
    logic             rise_tick;
    logic             fall_tick;
    logic             cfg_err;
    logic [CNT_W-1:0] cur_div;

    clk_div_prog #(.CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEF)) dut (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .en        (en),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .div_value (div_value),
        .div_high  (div_high),
        .clk_out   (clk_out),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .cfg_err   (cfg_err),
        .cur_div   (cur_div)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc++;

    typedef struct {
        bit is_rise;
        int at;
    } ev_t;

    ev_t evq[$];
    int  checks = 0;
    int  errors = 0;

    // Period-level model: enabled-edge index, start of the current period, ratio/high time
    int  en_cnt, pstart, m_n, m_h, p_n, p_h;
    bit  pend, m_ready;
    int  exp_cur;
    bit  exp_ready, exp_cfg;
    bit  mon_active = 1'b0;
    bit  prev_clk = 1'b0;

    function automatic int duty_of(int n, int h);
`ifdef CLK_DIV_DUTY_EN
        if (h == 0 || h >= n) return n / 2;
        return h;
`else
        return n / 2;
`endif
    endfunction

    function automatic void model_reset();
        en_cnt    = 0;
        pstart    = 1;
        m_n       = DIV_DEF;
        m_h       = DIV_DEF / 2;
        pend      = 1'b0;
        m_ready   = 1'b1;
        exp_cur   = DIV_DEF;
        exp_ready = 1'b1;
        exp_cfg   = 1'b0;
        evq.delete();
    endfunction

    // Drive inputs for the coming edge and advance the model across that edge
    task automatic drive(input bit e, input bit v, input int n, input int h);
        bit rdy0;
        en        = e;
        div_valid = v;
        div_value = CNT_W'(n);
        div_high  = CNT_W'(h);
        rdy0      = m_ready;
        exp_cfg   = 1'b0;
        if (e) begin
            en_cnt++;
            if (en_cnt == pstart)       evq.push_back(ev_t'{1'b1, cyc + 1});
            if (en_cnt == pstart + m_h) evq.push_back(ev_t'{1'b0, cyc + 1});
            if (en_cnt == pstart + m_n - 1) begin
                pstart = en_cnt + 1;
                if (pend) begin
                    m_n     = p_n;
                    m_h     = p_h;
                    pend    = 1'b0;
                    m_ready = 1'b1;
                end
            end
        end
        if (v && rdy0) begin
            if (n < 2) begin
                exp_cfg = 1'b1;
            end else begin
                pend    = 1'b1;
                p_n     = n;
                p_h     = duty_of(n, h);
                m_ready = 1'b0;
            end
        end
        exp_cur   = m_n;
        exp_ready = m_ready;
    endtask

    task automatic step(input bit e, input bit v, input int n, input int h);
        @(negedge clk_in);
        drive(e, v, n, h);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, 0, 0);
    endtask

    task automatic write_ratio(input int n, input int h);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk_in);
            done = m_ready;
            drive(1'b1, 1'b1, n, h);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL write_timeout n=%0d got never accepted, required accept within 2000 cycles", n);
        end
        $display("write n=%0d h=%0d at cyc %0d", n, h, cyc + 1);
    endtask

    task automatic check_reset_vals(input string tag);
        checks += 6;
        if (clk_out !== 1'b0)   begin errors++; $display("FAIL %s clk_out got %0b required 0", tag, clk_out); end
        if (rise_tick !== 1'b0) begin errors++; $display("FAIL %s rise_tick got %0b required 0", tag, rise_tick); end
        if (fall_tick !== 1'b0) begin errors++; $display("FAIL %s fall_tick got %0b required 0", tag, fall_tick); end
        if (cfg_err !== 1'b0)   begin errors++; $display("FAIL %s cfg_err got %0b required 0", tag, cfg_err); end
        if (div_ready !== 1'b1) begin errors++; $display("FAIL %s div_ready got %0b required 1", tag, div_ready); end
        if (int'(cur_div) != DIV_DEF || $isunknown(cur_div)) begin
            errors++;
            $display("FAIL %s cur_div got %0d required %0d", tag, cur_div, DIV_DEF);
        end
        $display("reset check %s done", tag);
    endtask

    task automatic release_reset();
        @(negedge clk_in);
        reset_n = 1'b1;
        model_reset();
        prev_clk   = 1'b0;
        mon_active = 1'b1;
        drive(1'b0, 1'b0, 0, 0);
    endtask

    // Monitor: pops predicted strobes and checks per-cycle status outputs
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (mon_active) begin
                while (evq.size() > 0 && evq[0].at < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL tick_missing %s got none at cyc %0d required at cyc %0d",
                             evq[0].is_rise ? "rise" : "fall", cyc, evq[0].at);
                    void'(evq.pop_front());
                end
                if (rise_tick || fall_tick) begin
                    checks++;
                    if (evq.size() == 0 || evq[0].at != cyc) begin
                        errors++;
                        $display("FAIL tick_unexpected got rise=%0b fall=%0b at cyc %0d required no tick",
                                 rise_tick, fall_tick, cyc);
                    end else begin
                        if ({rise_tick, fall_tick} !== {evq[0].is_rise, !evq[0].is_rise}) begin
                            errors++;
                            $display("FAIL tick_kind got rise=%0b fall=%0b at cyc %0d required rise=%0b",
                                     rise_tick, fall_tick, cyc, evq[0].is_rise);
                        end else begin
                            $display("tick %s at cyc %0d ok", rise_tick ? "rise" : "fall", cyc);
                        end
                        void'(evq.pop_front());
                    end
                end
                checks++;
                if ({rise_tick, fall_tick} !== {clk_out & ~prev_clk, ~clk_out & prev_clk}) begin
                    errors++;
                    $display("FAIL clk_edge got clk_out %0b->%0b rise=%0b fall=%0b at cyc %0d required strobes matching the edge",
                             prev_clk, clk_out, rise_tick, fall_tick, cyc);
                end
                prev_clk = clk_out;
                checks += 3;
                if (div_ready !== exp_ready) begin
                    errors++;
                    $display("FAIL div_ready got %0b required %0b at cyc %0d", div_ready, exp_ready, cyc);
                end
                if (cfg_err !== exp_cfg) begin
                    errors++;
                    $display("FAIL cfg_err got %0b required %0b at cyc %0d", cfg_err, exp_cfg, cyc);
                end
                if (int'(cur_div) != exp_cur || $isunknown(cur_div)) begin
                    errors++;
                    $display("FAIL cur_div got %0d required %0d at cyc %0d", cur_div, exp_cur, cyc);
                end
            end
        end
    end

    initial begin
        bit hit;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk_in);
        check_reset_vals("power_on");
        release_reset();

        // Default ratio 126: high 63 / low 63
        run(300);

        // Illegal ratio, then a legal one mid-period
        write_ratio(1, 0);
        run(20);
        write_ratio(5, 0);
        run(40);

        // Second write blocks until the first is applied
        write_ratio(7, 0);
        write_ratio(9, 0);
        run(40);

        // Programmable duty cases (ignored high time without the duty option)
        write_ratio(10, 3);
        run(40);
        write_ratio(8, 9);
        run(40);

        // Freeze mid high phase of a 40-cycle period
        write_ratio(40, 0);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            if (m_n == 40 && en_cnt - pstart == 9) hit = 1'b1;
            else step(1'b1, 1'b0, 0, 0);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL hold_setup got no 40-cycle period within 400 cycles required one");
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 0, 0);
            checks++;
            if (clk_out !== 1'b1) begin
                errors++;
                $display("FAIL hold_level got clk_out %0b required 1 at cyc %0d", clk_out, cyc);
            end
        end
        $display("hold of 40 cycles finished at cyc %0d", cyc);
        run(100);

        // Randomized enables and ratio writes
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 40) == 0)
                write_ratio(int'($urandom_range(0, 24)), int'($urandom_range(0, 26)));
            else
                step($urandom_range(0, 7) != 0, 1'b0, 0, 0);
        end

        // Reset mid-period with a ratio pending
        write_ratio(12, 5);
        run(3);
        @(posedge clk_in);
        #2;
        mon_active = 1'b0;
        reset_n    = 1'b0;
        #1;
        check_reset_vals("mid_period");
        model_reset();
        repeat (2) @(negedge clk_in);
        release_reset();
        run(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
